i2c_cmd_sequencer: RTL and testbench
====================================

I2C_CMD_SEQUENCER -- requirements
Module: i2c_cmd_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 4096: clk cycles allowed from launch to controller completion.
REQ-002 Parameter RST_CYCLES, default 32: length of the controller recovery reset pulse, in clk cycles.
REQ-003 clk  in  1  system clock; all logic on its rising edge.
REQ-004 rst  in  1  synchronous, active-low reset.
REQ-005 cmd_valid  in  1  command request.
REQ-006 cmd_ready  out  1  command accepted when high together with cmd_valid.
REQ-007 cmd_dev  in  7  I2C device address.
REQ-008 cmd_rw  in  1  0 = write one byte; 1 = write pointer byte, then repeated-start read of one byte.
REQ-009 cmd_wdata  in  8  data byte (write) or register pointer (read).
REQ-010 rsp_valid  out  1  response available.
REQ-011 rsp_ready  in  1  response consumed when high together with rsp_valid.
REQ-012 rsp_rdata  out  8  byte read; 0 for writes and errors.
REQ-013 rsp_err  out  1  transaction timed out.
REQ-014 err_count  out  8  saturating timeout counter.
REQ-015 ctl_addr  out  7,  ctl_data  out  8,  ctl_rw  out  1,  ctl_read  out  1  fields presented to the I2C controller.
REQ-016 ctl_enable  out  1  start request to the controller.
REQ-017 ctl_ready  in  1,  ctl_rdata  in  8  controller idle flag and read data.
REQ-018 ctl_rst  out  1  active-high reset to the controller, used only for recovery.

Function
REQ-019 The FSM SHALL have the states IDLE, LAUNCH, BUSY, RECOVER and RESP.
REQ-020 In IDLE, cmd_ready SHALL equal ctl_ready; on cmd_valid&&cmd_ready the block SHALL latch the command, clear the timer and enter LAUNCH.
REQ-021 Latched mapping SHALL be ctl_addr=cmd_dev, ctl_data=cmd_wdata, ctl_rw=0, ctl_read=cmd_rw, held stable from LAUNCH through BUSY.
REQ-022 In LAUNCH, ctl_enable SHALL be 1; the first cycle with ctl_ready==0 SHALL move the FSM to BUSY, and ctl_enable SHALL be 0 from that next cycle on.
REQ-023 In BUSY, ctl_ready==1 SHALL complete the transaction: rsp_rdata=ctl_rdata if ctl_read, else 0; rsp_err=0; go to RESP.
REQ-024 The timer SHALL run across LAUNCH and BUSY; when it reaches TIMEOUT_CYCLES-1 without completion the FSM SHALL enter RECOVER.
REQ-025 If completion and timeout occur in the same cycle, completion SHALL win.
REQ-026 RECOVER SHALL hold ctl_rst=1 and ctl_enable=0 for exactly RST_CYCLES cycles, then enter RESP with rsp_err=1, rsp_rdata=0, and err_count+1 (saturating at 255).
REQ-027 In RESP, rsp_valid SHALL be 1 with rsp_rdata/rsp_err stable until rsp_ready; the FSM SHALL then return to IDLE on the next cycle.
REQ-028 cmd_ready SHALL be 0 in every state except IDLE; cmd_valid outside IDLE SHALL be ignored.
REQ-029 After a handshake, the earliest new cmd_ready SHALL be the cycle after RESP exits.
REQ-030 The timer SHALL be at least 13 bits wide; TIMEOUT_CYCLES SHALL be at least RST_CYCLES+2.

Reset
REQ-031 While rst==0 at a clock edge: state=IDLE, and cmd_ready, rsp_valid, rsp_rdata, rsp_err, err_count, ctl_enable, ctl_rst, ctl_addr, ctl_data, ctl_rw, ctl_read and the timer SHALL all be 0.
REQ-032 Reset mid-transaction SHALL abort it with no response and no ctl_rst pulse; the controller is reset by the system reset.

Verification
REQ-033 Write: cmd_dev=0x48, cmd_rw=0, cmd_wdata=0xA5, model asserts ctl_ready low 10 cycles after enable and high 300 cycles later -> ctl_enable high until ctl_ready falls; rsp_valid with rsp_err=0, rsp_rdata=0x00.
REQ-034 Read: cmd_dev=0x68, cmd_rw=1, cmd_wdata=0x75, model returns ctl_rdata=0x71 -> ctl_read=1 during BUSY; response rsp_rdata=0x71, rsp_err=0.
REQ-035 Hang: ctl_ready stays 0 after launch -> at TIMEOUT_CYCLES, ctl_rst high for exactly 32 cycles; then rsp_err=1, rsp_rdata=0, err_count=1.
REQ-036 Backpressure: rsp_ready held 0 for 50 cycles -> rsp_valid and data stable; cmd_valid pulses are ignored; one cycle after rsp_ready=1, cmd_ready follows ctl_ready.
REQ-037 Race: ctl_ready rises on the exact timeout cycle -> success response, no ctl_rst, err_count unchanged; 256 forced timeouts -> err_count=255.
REQ-038 Reset: rst=0 during BUSY -> next cycle all outputs 0, state IDLE, no rsp_valid.

Source files
------------

// File: rtl/i2c_cmd_sequencer.sv
// Single-command I2C sequencer: accepts one write or pointer-read command, drives the
// controller, watches for a hang, resets the controller on timeout and returns a response.
module i2c_cmd_sequencer #(
  parameter int TIMEOUT_CYCLES = 4096,  // must be at least RST_CYCLES + 2
  parameter int RST_CYCLES     = 32     // must be at least 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [6:0] cmd_dev,
  input  logic       cmd_rw,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic [7:0] err_count,
  output logic [6:0] ctl_addr,
  output logic [7:0] ctl_data,
  output logic       ctl_rw,
  output logic       ctl_read,
  output logic       ctl_enable,
  input  logic       ctl_ready,
  input  logic [7:0] ctl_rdata,
  output logic       ctl_rst
);

  localparam int TW = ($clog2(TIMEOUT_CYCLES) > 13) ? $clog2(TIMEOUT_CYCLES) : 13;
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] RST_LAST     = TW'(RST_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LAUNCH  = 3'd1,
    BUSY    = 3'd2,
    RECOVER = 3'd3,
    RESP    = 3'd4
  } state_t;

  state_t        state_reg, state_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic [6:0]    addr_reg, addr_next;
  logic [7:0]    data_reg, data_next;
  logic          read_reg, read_next;
  logic [7:0]    rdata_reg, rdata_next;
  logic          err_reg, err_next;
  logic [7:0]    err_count_reg, err_count_next;
  logic          timed_out;

  assign timed_out = (timer_reg == TIMEOUT_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= IDLE;
      timer_reg     <= '0;
      addr_reg      <= '0;
      data_reg      <= '0;
      read_reg      <= 1'b0;
      rdata_reg     <= '0;
      err_reg       <= 1'b0;
      err_count_reg <= '0;
    end else begin
      state_reg     <= state_next;
      timer_reg     <= timer_next;
      addr_reg      <= addr_next;
      data_reg      <= data_next;
      read_reg      <= read_next;
      rdata_reg     <= rdata_next;
      err_reg       <= err_next;
      err_count_reg <= err_count_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    timer_next     = timer_reg;
    addr_next      = addr_reg;
    data_next      = data_reg;
    read_next      = read_reg;
    rdata_next     = rdata_reg;
    err_next       = err_reg;
    err_count_next = err_count_reg;

    case (state_reg)
      IDLE: begin
        if (cmd_valid && ctl_ready) begin
          addr_next  = cmd_dev;
          data_next  = cmd_wdata;
          read_next  = cmd_rw;
          timer_next = '0;
          state_next = LAUNCH;
        end
      end

      LAUNCH: begin
        // Timeout takes priority here: the controller has not completed anything yet,
        // and entering BUSY past the last count would leave the timer unable to expire.
        if (timed_out) begin
          timer_next = '0;
          state_next = RECOVER;
        end else begin
          timer_next = timer_reg + TW'(1);
          if (!ctl_ready) begin
            state_next = BUSY;
          end
        end
      end

      BUSY: begin
        if (ctl_ready) begin
          rdata_next = read_reg ? ctl_rdata : 8'h00;
          err_next   = 1'b0;
          state_next = RESP;
        end else if (timed_out) begin
          timer_next = '0;
          state_next = RECOVER;
        end else begin
          timer_next = timer_reg + TW'(1);
        end
      end

      RECOVER: begin
        if (timer_reg == RST_LAST) begin
          rdata_next     = 8'h00;
          err_next       = 1'b1;
          err_count_next = (err_count_reg == 8'hFF) ? 8'hFF : err_count_reg + 8'd1;
          state_next     = RESP;
        end else begin
          timer_next = timer_reg + TW'(1);
        end
      end

      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Gated with rst so the command port stays closed for the whole reset assertion.
  assign cmd_ready  = rst && (state_reg == IDLE) && ctl_ready;
  assign ctl_enable = (state_reg == LAUNCH);
  assign ctl_rst    = (state_reg == RECOVER);
  assign rsp_valid  = (state_reg == RESP);
  assign rsp_rdata  = rdata_reg;
  assign rsp_err    = err_reg;
  assign err_count  = err_count_reg;
  assign ctl_addr   = addr_reg;
  assign ctl_data   = data_reg;
  assign ctl_read   = read_reg;
  assign ctl_rw     = 1'b0;

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Directed bench for i2c_cmd_sequencer: a hand-driven controller model on the main
// instance, plus a short-timeout instance looping forced timeouts to saturate err_count.
module tb_i2c_cmd_sequencer;

  localparam int TO = 400;
  localparam int RC = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [6:0] cmd_dev = '0;
  logic       cmd_rw = 1'b0;
  logic [7:0] cmd_wdata = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic [7:0] err_count;
  logic [6:0] ctl_addr;
  logic [7:0] ctl_data;
  logic       ctl_rw;
  logic       ctl_read;
  logic       ctl_enable;
  logic       ctl_ready = 1'b1;
  logic [7:0] ctl_rdata = '0;
  logic       ctl_rst;

  // second instance: controller always idle, so every launch times out
  logic       s_cmd_valid = 1'b0;
  logic       s_cmd_ready;
  logic       s_rsp_valid;
  logic       s_rsp_ready = 1'b0;
  logic [7:0] s_rsp_rdata;
  logic       s_rsp_err;
  logic [7:0] s_err_count;
  logic [6:0] s_ctl_addr;
  logic [7:0] s_ctl_data;
  logic       s_ctl_rw;
  logic       s_ctl_read;
  logic       s_ctl_enable;
  logic       s_ctl_rst;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  i2c_cmd_sequencer #(.TIMEOUT_CYCLES(TO), .RST_CYCLES(RC)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dev(cmd_dev), .cmd_rw(cmd_rw),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .err_count(err_count),
    .ctl_addr(ctl_addr), .ctl_data(ctl_data), .ctl_rw(ctl_rw), .ctl_read(ctl_read),
    .ctl_enable(ctl_enable), .ctl_ready(ctl_ready), .ctl_rdata(ctl_rdata), .ctl_rst(ctl_rst)
  );

  i2c_cmd_sequencer #(.TIMEOUT_CYCLES(40), .RST_CYCLES(4)) dut_sat (
    .clk(clk), .rst(rst),
    .cmd_valid(s_cmd_valid), .cmd_ready(s_cmd_ready), .cmd_dev(7'h21), .cmd_rw(1'b1),
    .cmd_wdata(8'h0F),
    .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready), .rsp_rdata(s_rsp_rdata),
    .rsp_err(s_rsp_err), .err_count(s_err_count),
    .ctl_addr(s_ctl_addr), .ctl_data(s_ctl_data), .ctl_rw(s_ctl_rw), .ctl_read(s_ctl_read),
    .ctl_enable(s_ctl_enable), .ctl_ready(1'b1), .ctl_rdata(8'hC3), .ctl_rst(s_ctl_rst)
  );

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge of the first LAUNCH cycle.
  task automatic send_cmd(input logic [6:0] dev, input logic rw, input logic [7:0] wd,
                          output bit ok);
    cmd_dev = dev; cmd_rw = rw; cmd_wdata = wd; cmd_valid = 1'b1; ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      if (cmd_ready === 1'b1) ok = 1'b1;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; ctl_ready = 1'b1;
    step(3);
    n_cmp++;
    if ({cmd_ready, rsp_valid, rsp_rdata, rsp_err, err_count, ctl_enable, ctl_rst,
         ctl_addr, ctl_data, ctl_rw, ctl_read} !== 38'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b required all zero",
               {cmd_ready, rsp_valid, rsp_rdata, rsp_err, err_count, ctl_enable, ctl_rst,
                ctl_addr, ctl_data, ctl_rw, ctl_read});
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_release_ready: got %b required 1", cmd_ready);
    end
    step(1);
    $display("reset: done, outputs checked");
  endtask

  task automatic test_write();
    bit ok;
    ctl_rdata = 8'h5C;
    send_cmd(7'h48, 1'b0, 8'hA5, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL write_accept: got no handshake required one"); end
    n_cmp++;
    if ({ctl_enable, ctl_addr, ctl_data, ctl_rw, ctl_read, cmd_ready} !== {1'b1, 7'h48, 8'hA5, 1'b0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL write_launch: en=%b addr=%h data=%h rw=%b rd=%b rdy=%b required 1 48 a5 0 0 0",
               ctl_enable, ctl_addr, ctl_data, ctl_rw, ctl_read, cmd_ready);
    end
    step(9);
    n_cmp++;
    if (ctl_enable !== 1'b1) begin
      n_bad++; $display("FAIL write_enable_held: got %b required 1", ctl_enable);
    end
    ctl_ready = 1'b0;
    step(1);
    n_cmp++;
    if ({ctl_enable, ctl_addr, ctl_data} !== {1'b0, 7'h48, 8'hA5}) begin
      n_bad++;
      $display("FAIL write_busy: en=%b addr=%h data=%h required 0 48 a5",
               ctl_enable, ctl_addr, ctl_data);
    end
    step(299);
    ctl_ready = 1'b1;
    step(1);
    n_cmp++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 8'h00}) begin
      n_bad++;
      $display("FAIL write_resp: valid=%b err=%b rdata=%h required 1 0 00",
               rsp_valid, rsp_err, rsp_rdata);
    end
    rsp_ready = 1'b1;
    #1;
    n_cmp++;
    if (cmd_ready !== 1'b0) begin
      n_bad++; $display("FAIL write_ready_in_resp: got %b required 0", cmd_ready);
    end
    step(1);
    rsp_ready = 1'b0;
    #1;
    n_cmp++;
    if ({cmd_ready, rsp_valid} !== 2'b10) begin
      n_bad++; $display("FAIL write_back_idle: rdy=%b valid=%b required 1 0", cmd_ready, rsp_valid);
    end
    step(1);
    $display("write: dev=48 data=a5 -> rsp checked");
  endtask

  task automatic test_read();
    bit ok;
    ctl_rdata = 8'h71;
    send_cmd(7'h68, 1'b1, 8'h75, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL read_accept: got no handshake required one"); end
    step(2);
    ctl_ready = 1'b0;
    step(1);
    n_cmp++;
    if ({ctl_read, ctl_rw, ctl_addr, ctl_data, ctl_enable} !== {1'b1, 1'b0, 7'h68, 8'h75, 1'b0}) begin
      n_bad++;
      $display("FAIL read_busy_fields: rd=%b rw=%b addr=%h data=%h en=%b required 1 0 68 75 0",
               ctl_read, ctl_rw, ctl_addr, ctl_data, ctl_enable);
    end
    step(19);
    ctl_ready = 1'b1;
    step(1);
    ctl_rdata = 8'h00;
    #1;
    n_cmp++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 8'h71}) begin
      n_bad++;
      $display("FAIL read_resp: valid=%b err=%b rdata=%h required 1 0 71",
               rsp_valid, rsp_err, rsp_rdata);
    end
    rsp_ready = 1'b1;
    step(1);
    rsp_ready = 1'b0;
    step(1);
    $display("read: dev=68 ptr=75 -> rdata checked");
  endtask

  task automatic test_hang();
    bit ok;
    int cnt;
    ctl_rdata = 8'hEE;
    send_cmd(7'h50, 1'b1, 8'h10, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL hang_accept: got no handshake required one"); end
    ctl_ready = 1'b0;
    step(TO - 1);
    n_cmp++;
    if ({ctl_rst, rsp_valid} !== 2'b00) begin
      n_bad++; $display("FAIL hang_early: rst=%b valid=%b required 0 0", ctl_rst, rsp_valid);
    end
    step(1);
    n_cmp++;
    if ({ctl_rst, ctl_enable} !== 2'b10) begin
      n_bad++; $display("FAIL hang_recover_start: rst=%b en=%b required 1 0", ctl_rst, ctl_enable);
    end
    cnt = 0;
    while (ctl_rst === 1'b1 && cnt < 100) begin
      cnt++;
      step(1);
    end
    n_cmp++;
    if (cnt != RC) begin
      n_bad++; $display("FAIL hang_rst_len: got %0d cycles required %0d", cnt, RC);
    end
    n_cmp++;
    if ({rsp_valid, rsp_err, rsp_rdata, err_count} !== {1'b1, 1'b1, 8'h00, 8'd1}) begin
      n_bad++;
      $display("FAIL hang_resp: valid=%b err=%b rdata=%h cnt=%0d required 1 1 00 1",
               rsp_valid, rsp_err, rsp_rdata, err_count);
    end
    ctl_ready = 1'b1;
    rsp_ready = 1'b1;
    step(1);
    rsp_ready = 1'b0;
    step(1);
    $display("hang: timeout, ctl_rst %0d cycles, err_count=%0d", cnt, err_count);
  endtask

  task automatic test_backpressure();
    bit ok;
    int bad;
    ctl_rdata = 8'h3C;
    send_cmd(7'h2A, 1'b1, 8'h01, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL bp_accept: got no handshake required one"); end
    ctl_ready = 1'b0;
    step(5);
    ctl_ready = 1'b1;
    step(1);
    ctl_rdata = 8'hFF;
    cmd_dev = 7'h11;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      cmd_valid = (i % 2 == 1);
      #1;
      if (!(rsp_valid === 1'b1 && rsp_rdata === 8'h3C && rsp_err === 1'b0 &&
            cmd_ready === 1'b0 && ctl_enable === 1'b0 && ctl_addr === 7'h2A)) bad++;
      step(1);
    end
    cmd_valid = 1'b0;
    n_cmp++;
    if (bad != 0) begin
      n_bad++; $display("FAIL bp_stable: got %0d bad cycles required 0", bad);
    end
    rsp_ready = 1'b1;
    step(1);
    rsp_ready = 1'b0;
    #1;
    n_cmp++;
    if ({cmd_ready, rsp_valid} !== 2'b10) begin
      n_bad++; $display("FAIL bp_release: rdy=%b valid=%b required 1 0", cmd_ready, rsp_valid);
    end
    ctl_ready = 1'b0;
    #1;
    n_cmp++;
    if (cmd_ready !== 1'b0) begin
      n_bad++; $display("FAIL bp_follow_ctl: got %b required 0", cmd_ready);
    end
    ctl_ready = 1'b1;
    step(1);
    n_cmp++;
    if (ctl_enable !== 1'b0) begin
      n_bad++; $display("FAIL bp_no_launch: got %b required 0", ctl_enable);
    end
    $display("backpressure: 50 stalled cycles, rdata=3c held");
  endtask

  task automatic test_race();
    bit ok;
    ctl_rdata = 8'h99;
    send_cmd(7'h3B, 1'b0, 8'h42, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL race_accept: got no handshake required one"); end
    ctl_ready = 1'b0;
    step(TO - 1);
    ctl_ready = 1'b1;
    step(1);
    n_cmp++;
    if ({ctl_rst, rsp_valid, rsp_err, rsp_rdata, err_count} !== {1'b0, 1'b1, 1'b0, 8'h00, 8'd1}) begin
      n_bad++;
      $display("FAIL race_resp: rst=%b valid=%b err=%b rdata=%h cnt=%0d required 0 1 0 00 1",
               ctl_rst, rsp_valid, rsp_err, rsp_rdata, err_count);
    end
    rsp_ready = 1'b1;
    step(1);
    rsp_ready = 1'b0;
    step(1);
    $display("race: completion on timeout cycle -> success");
  endtask

  task automatic test_reset_mid();
    bit ok;
    send_cmd(7'h55, 1'b1, 8'hAA, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL rstmid_accept: got no handshake required one"); end
    ctl_ready = 1'b0;
    step(5);
    rst = 1'b0;
    ctl_ready = 1'b1;
    step(1);
    n_cmp++;
    if ({cmd_ready, rsp_valid, rsp_rdata, rsp_err, err_count, ctl_enable, ctl_rst,
         ctl_addr, ctl_data, ctl_rw, ctl_read} !== 38'd0) begin
      n_bad++;
      $display("FAIL rstmid_outputs: got %b required all zero",
               {cmd_ready, rsp_valid, rsp_rdata, rsp_err, err_count, ctl_enable, ctl_rst,
                ctl_addr, ctl_data, ctl_rw, ctl_read});
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_bad++; $display("FAIL rstmid_idle: got %b required 1", cmd_ready);
    end
    step(2);
    n_cmp++;
    if ({rsp_valid, ctl_rst, ctl_enable} !== 3'b000) begin
      n_bad++;
      $display("FAIL rstmid_quiet: valid=%b rst=%b en=%b required 0 0 0", rsp_valid, ctl_rst, ctl_enable);
    end
    $display("reset_mid: busy transaction aborted");
  endtask

  task automatic test_saturate();
    int n;
    n = 0;
    s_cmd_valid = 1'b1;
    s_rsp_ready = 1'b1;
    for (int c = 0; c < 20000 && n < 256; c++) begin
      if (s_rsp_valid === 1'b1) begin
        n++;
        if (n == 1) begin
          n_cmp++;
          if (s_err_count !== 8'd1) begin
            n_bad++; $display("FAIL sat_first: got %0d required 1", s_err_count);
          end
        end
        if (n == 255) begin
          n_cmp++;
          if (s_err_count !== 8'd255) begin
            n_bad++; $display("FAIL sat_255: got %0d required 255", s_err_count);
          end
        end
        if (n == 256) begin
          n_cmp++;
          if ({s_err_count, s_rsp_err, s_rsp_rdata} !== {8'd255, 1'b1, 8'h00}) begin
            n_bad++;
            $display("FAIL sat_256: cnt=%0d err=%b rdata=%h required 255 1 00",
                     s_err_count, s_rsp_err, s_rsp_rdata);
          end
        end
      end
      step(1);
    end
    s_cmd_valid = 1'b0;
    n_cmp++;
    if (n != 256) begin
      n_bad++; $display("FAIL sat_count: got %0d responses required 256", n);
    end
    $display("saturate: %0d forced timeouts, err_count=%0d", n, s_err_count);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_write();
    test_read();
    test_hang();
    test_backpressure();
    test_race();
    test_reset_mid();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
